// File: rtl/bank_reader_pkg.sv
// Shared types and helpers for the bank batch reader.
// Optional prefetch path: BANK_READER_PREFETCH_EN.
package bank_reader_pkg;

  localparam int DEF_CHANNEL_COUNT = 3;
  localparam int DEF_BATCH_SIZE    = 16;
  localparam int DEF_BLOCK_DEPTH   = 480;
  localparam int DEF_COUNT_BITS    = 10;

  localparam int ADDR_BITS = $clog2(DEF_BLOCK_DEPTH);
  localparam int IDX_BITS  = $clog2(DEF_BATCH_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [31:0] wrap_inc(
    input logic [31:0] a,
    input logic [31:0] depth
  );
    return (a == depth - 32'd1) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/bank_batch_reader_unpacker.sv
// Holding register(s), byte index and byte-select mux for all channels.
// BANK_READER_PREFETCH_EN adds a shadow word swapped in on the last byte.
module batch_unpacker
  import bank_reader_pkg::*;
#(
  parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
  parameter int BATCH_SIZE    = DEF_BATCH_SIZE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_advance,
`ifdef BANK_READER_PREFETCH_EN
  input  logic i_shadow_load,
  input  logic i_swap,
`endif
  input  logic i_show,
  input  logic [0:CHANNEL_COUNT-1][8*BATCH_SIZE-1:0] i_data,
  output logic [0:CHANNEL_COUNT-1][7:0] o_pixel,
  output logic o_last
);

  localparam int IW = $clog2(BATCH_SIZE);

  logic [0:CHANNEL_COUNT-1][8*BATCH_SIZE-1:0] r_hold;
  logic [IW-1:0] r_idx;
  logic [IW+2:0] w_sel;

`ifdef BANK_READER_PREFETCH_EN
  logic [0:CHANNEL_COUNT-1][8*BATCH_SIZE-1:0] r_shadow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else if (i_shadow_load) begin
      r_shadow <= i_data;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_hold <= i_data;
      r_idx  <= '0;
`ifdef BANK_READER_PREFETCH_EN
    end else if (i_swap) begin
      r_hold <= r_shadow;
      r_idx  <= '0;
`endif
    end else if (i_advance) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign w_sel  = {r_idx, 3'b000};
  assign o_last = (r_idx == IW'(BATCH_SIZE - 1));

  // Byte 0 sits in the LSBs; output is forced to zero when not valid.
  always_comb begin
    o_pixel = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      o_pixel[c] = i_show ? r_hold[c][w_sel +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/bank_batch_reader.sv
// Fetches packed batches from the channel banks and streams pixels out.
// BANK_READER_PREFETCH_EN overlaps the next read with the current batch.
module bank_batch_reader
  import bank_reader_pkg::*;
#(
  parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
  parameter int BATCH_SIZE    = DEF_BATCH_SIZE,
  parameter int BLOCK_DEPTH   = DEF_BLOCK_DEPTH,
  parameter int COUNT_BITS    = DEF_COUNT_BITS
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_start,
  input  logic [$clog2(BLOCK_DEPTH)-1:0] I_base_address,
  input  logic [COUNT_BITS-1:0] I_batch_count,
  output logic O_rd_en,
  output logic [$clog2(BLOCK_DEPTH)-1:0] O_rd_address,
  input  logic [0:CHANNEL_COUNT-1][8*BATCH_SIZE-1:0] I_rd_data,
  output logic [0:CHANNEL_COUNT-1][7:0] O_pixel,
  output logic O_pixel_valid,
  input  logic I_pixel_ready,
  output logic O_busy,
  output logic O_done
);

  localparam int AW = $clog2(BLOCK_DEPTH);

  state_t r_state;
  logic r_rd_en;
  logic [AW-1:0] r_rd_address;
  logic [AW-1:0] r_addr;
  logic [COUNT_BITS-1:0] r_count;
  logic r_valid;
  logic r_busy;
  logic r_done;

  logic [AW-1:0] w_next_addr;
  logic w_transfer;
  logic w_last;
  logic w_load;
  logic w_advance;

  assign w_next_addr = AW'(wrap_inc(32'(r_addr), 32'(BLOCK_DEPTH)));
  assign w_transfer  = r_valid & I_pixel_ready;
  assign w_load      = (r_state == WAIT);
  assign w_advance   = w_transfer & ~w_last;

`ifdef BANK_READER_PREFETCH_EN
  logic r_pf_cap;
  logic w_swap;
  logic w_shadow_load;

  assign w_swap = w_transfer & w_last
                & (r_count != COUNT_BITS'(1));
  assign w_shadow_load = r_pf_cap & (r_state == SHIFT);
`endif

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state      <= IDLE;
      r_rd_en      <= 1'b0;
      r_rd_address <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef BANK_READER_PREFETCH_EN
      r_pf_cap     <= 1'b0;
`endif
    end else begin
      r_rd_en      <= 1'b0;
      r_rd_address <= '0;
      r_done       <= 1'b0;
`ifdef BANK_READER_PREFETCH_EN
      r_pf_cap     <= r_rd_en;
`endif
      unique case (r_state)
        IDLE: begin
          if (I_start) begin
            r_busy  <= 1'b1;
            r_addr  <= I_base_address;
            r_count <= I_batch_count;
            if (I_batch_count == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_rd_en      <= 1'b1;
              r_rd_address <= I_base_address;
              r_state      <= FETCH;
            end
          end
        end
        FETCH: r_state <= WAIT;
        WAIT: begin
          r_valid <= 1'b1;
          r_state <= SHIFT;
`ifdef BANK_READER_PREFETCH_EN
          if (r_count > COUNT_BITS'(1)) begin
            r_rd_en      <= 1'b1;
            r_rd_address <= w_next_addr;
            r_addr       <= w_next_addr;
          end
`endif
        end
        SHIFT: begin
          if (w_transfer && w_last) begin
            r_count <= r_count - COUNT_BITS'(1);
            if (r_count == COUNT_BITS'(1)) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
`ifdef BANK_READER_PREFETCH_EN
              // Shadow already holds this batch; fetch the one after it.
              if (r_count > COUNT_BITS'(2)) begin
                r_rd_en      <= 1'b1;
                r_rd_address <= w_next_addr;
                r_addr       <= w_next_addr;
              end
`else
              r_valid      <= 1'b0;
              r_rd_en      <= 1'b1;
              r_rd_address <= w_next_addr;
              r_addr       <= w_next_addr;
              r_state      <= FETCH;
`endif
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  batch_unpacker #(
    .CHANNEL_COUNT(CHANNEL_COUNT),
    .BATCH_SIZE   (BATCH_SIZE)
  ) u_unpacker (
    .i_clk        (I_clk),
    .i_rst        (I_rst),
    .i_load       (w_load),
    .i_advance    (w_advance),
`ifdef BANK_READER_PREFETCH_EN
    .i_shadow_load(w_shadow_load),
    .i_swap       (w_swap),
`endif
    .i_show       (r_valid),
    .i_data       (I_rd_data),
    .o_pixel      (O_pixel),
    .o_last       (w_last)
  );

  assign O_rd_en       = r_rd_en;
  assign O_rd_address  = r_rd_address;
  assign O_pixel_valid = r_valid;
  assign O_busy        = r_busy;
  assign O_done        = r_done;

endmodule

// File: tb/tb_bank_batch_reader.sv
// Directed, table-driven bench for bank_batch_reader.
// Works with or without BANK_READER_PREFETCH_EN.
module tb_bank_batch_reader;

  localparam int CH = 3;
  localparam int BS = 16;
  localparam int DEPTH = 480;
  localparam int CB = 10;
  localparam int AW = 9;
`ifdef BANK_READER_PREFETCH_EN
  localparam int BUB = 0;
`else
  localparam int BUB = 2;
`endif

  typedef logic [0:CH-1][7:0] pix_t;

  typedef struct {
    int base;
    int cnt;
    int rmode;
    bit salt;
    int exp_reads;
    int exp_first_addr;
    int exp_last_addr;
    logic [23:0] exp_first_pix;
  } vec_t;

  logic I_clk = 1'b0;
  logic I_rst = 1'b1;
  logic I_start = 1'b0;
  logic [AW-1:0] I_base_address = '0;
  logic [CB-1:0] I_batch_count = '0;
  logic O_rd_en;
  logic [AW-1:0] O_rd_address;
  logic [0:CH-1][8*BS-1:0] I_rd_data = '0;
  pix_t O_pixel;
  logic O_pixel_valid;
  logic I_pixel_ready = 1'b0;
  logic O_busy;
  logic O_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit salt = 1'b0;
  pix_t got[$];
  int xfer_cyc[$];
  int rd_q[$];
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid = -1;
  bit prev_stall = 1'b0;
  pix_t prev_pix;

  bank_batch_reader dut (
    .I_clk         (I_clk),
    .I_rst         (I_rst),
    .I_start       (I_start),
    .I_base_address(I_base_address),
    .I_batch_count (I_batch_count),
    .O_rd_en       (O_rd_en),
    .O_rd_address  (O_rd_address),
    .I_rd_data     (I_rd_data),
    .O_pixel       (O_pixel),
    .O_pixel_valid (O_pixel_valid),
    .I_pixel_ready (I_pixel_ready),
    .O_busy        (O_busy),
    .O_done        (O_done)
  );

  always #5 I_clk = ~I_clk;

  always @(posedge I_clk) cyc = cyc + 1;

  function automatic logic [7:0] bbyte(input int a, input int c, input int k);
    logic [7:0] v;
    v = 8'((c << 4) | k);
    if (salt) v = v ^ 8'(a);
    return v;
  endfunction

  function automatic pix_t exp_pix(input int a, input int k);
    pix_t p;
    for (int c = 0; c < CH; c++) p[c] = bbyte(a, c, k);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Bank model: word data valid the cycle after the read strobe
  always @(posedge I_clk) begin
    if (O_rd_en) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < BS; k++)
          I_rd_data[c][8*k +: 8] <= bbyte(int'(O_rd_address), c, k);
    end
  end

  always @(posedge I_clk) begin
    #1;
    case (rdy_mode)
      0: I_pixel_ready = 1'b1;
      1: I_pixel_ready = 1'($urandom_range(0, 1));
      default: I_pixel_ready = 1'b0;
    endcase
  end

  always @(negedge I_clk) begin
    if (I_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {O_pixel_valid, O_pixel}, {1'b1, prev_pix});
      if (!O_pixel_valid)
        chk("idle_zero", O_pixel, 0);
      if (O_pixel_valid && first_valid < 0) first_valid = cyc;
      if (O_pixel_valid && I_pixel_ready) begin
        got.push_back(O_pixel);
        xfer_cyc.push_back(cyc);
      end
      if (O_rd_en) rd_q.push_back(int'(O_rd_address));
      if (O_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = O_pixel_valid && !I_pixel_ready;
      prev_pix = O_pixel;
    end
  end

  task automatic start(input int base, input int cnt, input int rmode,
                       input bit sl, output int s);
    @(posedge I_clk);
    #1;
    got.delete();
    xfer_cyc.delete();
    rd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_valid = -1;
    salt = sl;
    rdy_mode = rmode;
    I_base_address = AW'(base);
    I_batch_count = CB'(cnt);
    I_start = 1'b1;
    s = cyc;
    @(posedge I_clk);
    #1;
    I_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge I_clk);
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) @(negedge I_clk);
  endtask

  task automatic check_stream(input int base, input int cnt);
    int bad = 0;
    int n;
    n = cnt * BS;
    chk("xfers", got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) begin
      if (got[i] !== exp_pix((base + i / BS) % DEPTH, i % BS)) bad++;
    end
    chk("data", bad, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int s;
    int n;
    vecs[0] = '{5,   2, 0, 1'b0, 2, 5,   6,   24'h001020};
    vecs[1] = '{479, 2, 0, 1'b0, 2, 479, 0,   24'h001020};
    vecs[2] = '{0,   0, 0, 1'b0, 0, 0,   0,   24'h000000};
    vecs[3] = '{100, 3, 1, 1'b1, 3, 100, 102, 24'h647444};
    vecs[4] = '{478, 3, 1, 1'b1, 3, 478, 0,   24'hDECEFE};
    vecs[5] = '{20,  3, 0, 1'b1, 3, 20,  22,  24'h140434};

    repeat (2) @(negedge I_clk);
    chk("reset_outs", {O_rd_en, O_rd_address, O_pixel, O_pixel_valid,
                       O_busy, O_done}, 0);
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    repeat (2) @(negedge I_clk);
    chk("idle_busy", O_busy, 0);

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].base, vecs[i].cnt, vecs[i].rmode, vecs[i].salt, s);
      wait_done();
      chk("done_once", done_cnt, 1);
      chk("busy_end", O_busy, 0);
      chk("reads", rd_q.size(), vecs[i].exp_reads);
      if (vecs[i].exp_reads > 0 && rd_q.size() > 0) begin
        chk("first_addr", rd_q[0], vecs[i].exp_first_addr);
        chk("last_addr", rd_q[rd_q.size()-1], vecs[i].exp_last_addr);
      end
      check_stream(vecs[i].base, vecs[i].cnt);
      if (vecs[i].cnt > 0) begin
        chk("latency", first_valid - s, 3);
        chk("first_pix", got.size() > 0 ? got[0] : 'x,
            vecs[i].exp_first_pix);
      end else begin
        chk("done_lat", done_cyc - s, 1);
      end
      if (vecs[i].rmode == 0 && vecs[i].cnt > 0 && xfer_cyc.size() > 0)
        chk("span", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0],
            vecs[i].cnt * BS - 1 + (vecs[i].cnt - 1) * BUB);
    end

    // Start while busy must be ignored
    start(200, 2, 0, 1'b1, s);
    n = 0;
    while (got.size() < 5 && n < 200) begin
      @(negedge I_clk);
      n++;
    end
    @(posedge I_clk);
    #1;
    I_base_address = AW'(100);
    I_batch_count = CB'(7);
    I_start = 1'b1;
    @(posedge I_clk);
    #1;
    I_start = 1'b0;
    wait_done();
    chk("busy_done_once", done_cnt, 1);
    chk("busy_reads", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("busy_addr0", rd_q[0], 200);
      chk("busy_addr1", rd_q[1], 201);
    end
    check_stream(200, 2);

    // Reset in the middle of the first batch, at byte 7
    start(5, 2, 0, 1'b0, s);
    n = 0;
    while (!(O_pixel_valid && O_pixel[0] == 8'h07) && n < 100) begin
      @(negedge I_clk);
      n++;
    end
    chk("reach_k7", O_pixel[0], 8'h07);
    #2;
    I_rst = 1'b1;
    #1;
    chk("async_reset", {O_rd_en, O_rd_address, O_pixel, O_pixel_valid,
                        O_busy, O_done}, 0);
    repeat (2) @(negedge I_clk);
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    repeat (4) @(negedge I_clk);
    chk("no_done_abort", done_cnt, 0);
    chk("idle_after_rst", {O_busy, O_pixel_valid}, 0);

    start(7, 1, 1, 1'b1, s);
    wait_done();
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_reads", rd_q.size(), 1);
    if (rd_q.size() == 1) chk("post_rst_addr", rd_q[0], 7);
    check_stream(7, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
